// File: rtl/sfq_pkg.sv
// Shared types and defaults for the toggle-encoded SFQ pulse transmitter.
// Default timing matches the downstream cell library's begin_time and hold window.
package sfq_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EMIT,
    ST_GAP
  } sfq_state_e;

  localparam int unsigned SFQ_MIN_GAP     = 3;
  localparam int unsigned SFQ_INIT_CYCLES = 4;
  localparam int unsigned SFQ_TMR_W       = 16;

  // Cycles spent waiting between two transitions, not counting the EMIT cycle.
  function automatic int unsigned gap_wait(int unsigned min_gap);
    return min_gap - 1;
  endfunction

endpackage

// File: rtl/sfq_gap_timer.sv
// Loadable saturating down-counter; done once the count is at or below one.
// Shared by the init window, the inter-pulse gap and the inter-burst holdoff.
module sfq_gap_timer
  import sfq_pkg::*;
#(
  parameter int unsigned    W        = SFQ_TMR_W,
  parameter logic [W-1:0]   RST_VAL  = '0,
  parameter logic [W-1:0]   LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/sfq_toggle_tx.sv
// Burst-to-pulse transmitter driving a toggle-encoded SFQ line.
// Each EMIT cycle flips q once; the timer spaces flips by MIN_GAP cycles.
module sfq_toggle_tx
  import sfq_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_GAP     = SFQ_MIN_GAP,
  parameter int unsigned INIT_CYCLES = SFQ_INIT_CYCLES,
  parameter int unsigned TOT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             q,
  output logic             busy,
  output logic [TOT_W-1:0] pulses_sent
);

  localparam logic [SFQ_TMR_W-1:0] INIT_LD =
    SFQ_TMR_W'(INIT_CYCLES);
  localparam logic [SFQ_TMR_W-1:0] GAP_LD =
    SFQ_TMR_W'(gap_wait(MIN_GAP));

  sfq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             q_q, q_d;
  logic [TOT_W-1:0] pulses_q, pulses_d;
  logic             ready;
  logic             t_load;
  logic             t_dec;
  logic             t_done;

  sfq_gap_timer #(
    .W        (SFQ_TMR_W),
    .RST_VAL  (INIT_LD),
    .LOAD_VAL (GAP_LD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .dec  (t_dec),
    .done (t_done)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    q_d      = q_q;
    pulses_d = pulses_q;
    ready    = 1'b0;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        t_dec = 1'b1;
        if (t_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // timer doubles as the holdoff after the last pulse of a burst
        t_dec = 1'b1;
        ready = t_done;
        if (req_valid && ready && (req_count != '0)) begin
          rem_d   = req_count;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        q_d      = ~q_q;
        pulses_d = pulses_q + TOT_W'(1);
        rem_d    = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          t_load  = 1'b1;
        end else if (MIN_GAP == 1) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_GAP;
          t_load  = 1'b1;
        end
      end
      ST_GAP: begin
        if (t_done) begin
          state_d = ST_EMIT;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      rem_q    <= '0;
      q_q      <= 1'b0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      pulses_q <= pulses_d;
    end
  end

  assign req_ready   = ready;
  assign q           = q_q;
  assign busy        = (state_q == ST_EMIT) || (state_q == ST_GAP);
  assign pulses_sent = pulses_q;

endmodule

// File: tb/tb_sfq_toggle_tx.sv
// Bench for sfq_toggle_tx: three instances (MIN_GAP 3, 1, 4) checked every
// cycle against a schedule-based model, plus table and directed sequences.
module tb_sfq_toggle_tx;

  localparam int INIT = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i [3];
  logic       rv    [3];
  logic [7:0] rc    [3];
  logic       q_o   [3];
  logic       rdy_o [3];
  logic       busy_o[3];
  logic [15:0] ps_o [3];

  int errs   = 0;
  int checks = 0;

  sfq_toggle_tx #(.CNT_W(8), .MIN_GAP(3), .INIT_CYCLES(INIT), .TOT_W(16)) u0 (
    .clk(clk), .rst(rst_i[0]), .req_valid(rv[0]), .req_count(rc[0]),
    .req_ready(rdy_o[0]), .q(q_o[0]), .busy(busy_o[0]), .pulses_sent(ps_o[0]));
  sfq_toggle_tx #(.CNT_W(8), .MIN_GAP(1), .INIT_CYCLES(INIT), .TOT_W(16)) u1 (
    .clk(clk), .rst(rst_i[1]), .req_valid(rv[1]), .req_count(rc[1]),
    .req_ready(rdy_o[1]), .q(q_o[1]), .busy(busy_o[1]), .pulses_sent(ps_o[1]));
  sfq_toggle_tx #(.CNT_W(8), .MIN_GAP(4), .INIT_CYCLES(INIT), .TOT_W(16)) u2 (
    .clk(clk), .rst(rst_i[2]), .req_valid(rv[2]), .req_count(rc[2]),
    .req_ready(rdy_o[2]), .q(q_o[2]), .busy(busy_o[2]), .pulses_sent(ps_o[2]));

  function automatic int gap_of(int i);
    case (i)
      0: return 3;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the burst is a schedule of transition edges
  // first+k*gap; acceptance is allowed from a precomputed edge onward.
  int edge_n = 0;
  bit m_valid  [3] = '{0, 0, 0};
  bit rst_seen [3] = '{0, 0, 0};
  int m_q      [3];
  int m_cnt    [3];
  int ready_at [3];
  int tx_next  [3];
  int tx_left  [3];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      rst_seen[i] = rst_i[i];
      if (rst_i[i]) begin
        m_valid[i]  = 1;
        m_q[i]      = 0;
        m_cnt[i]    = 0;
        tx_left[i]  = 0;
        tx_next[i]  = 0;
        ready_at[i] = edge_n + ((INIT > 1) ? INIT : 1) + 1;
      end else if (m_valid[i]) begin
        if (tx_left[i] > 0 && edge_n == tx_next[i]) begin
          m_q[i]     = 1 - m_q[i];
          m_cnt[i]   = (m_cnt[i] + 1) % 65536;
          tx_left[i] = tx_left[i] - 1;
          tx_next[i] = tx_next[i] + gap_of(i);
        end else if (rv[i] && edge_n >= ready_at[i] && int'(rc[i]) > 0) begin
          tx_next[i]  = edge_n + 1;
          tx_left[i]  = int'(rc[i]);
          ready_at[i] = edge_n + 1 + (int'(rc[i]) - 1) * gap_of(i)
                        + ((gap_of(i) > 2) ? gap_of(i) - 1 : 1);
        end
      end
    end
  end

  logic prev_q  [3];
  int   last_chg[3] = '{-1, -1, -1};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        chk($sformatf("q[%0d]", i), q_o[i], m_q[i]);
        chk($sformatf("pulses[%0d]", i), ps_o[i], m_cnt[i]);
        chk($sformatf("busy[%0d]", i), busy_o[i], tx_left[i] > 0);
        chk($sformatf("ready[%0d]", i), rdy_o[i], edge_n + 1 >= ready_at[i]);
        if (rst_seen[i]) begin
          last_chg[i] = -1;
          prev_q[i]   = q_o[i];
        end else if (q_o[i] !== prev_q[i]) begin
          if (last_chg[i] >= 0) begin
            checks++;
            if (edge_n - last_chg[i] < gap_of(i)) begin
              errs++;
              $display("FAIL spacing[%0d]: got %0d cycles required >= %0d",
                       i, edge_n - last_chg[i], gap_of(i));
            end
          end
          last_chg[i] = edge_n;
          prev_q[i]   = q_o[i];
        end
      end
    end
  end

  task automatic wait_ready(int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_o[i] !== 1'b1 && n < 500);
    if (rdy_o[i] !== 1'b1) begin
      checks++;
      errs++;
      $display("FAIL wait_ready[%0d]: got 0 expected 1 within 500 cycles", i);
    end
  endtask

  task automatic do_req(int i, int c);
    wait_ready(i);
    rv[i] = 1'b1;
    rc[i] = 8'(c);
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, output int len);
    len = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (busy_o[i] !== 1'b1) return;
      len++;
    end
    checks++;
    errs++;
    $display("FAIL wait_idle[%0d]: got busy expected idle within 500 cycles", i);
  endtask

  typedef struct {
    int cnt;
    int exp_len;
    int exp_q;
    int exp_tot;
  } vec_t;

  vec_t tbl[6];
  bit   acc[3];
  int   len;
  int   base;

  initial begin
    tbl[0] = '{3, 7, 1, 3};
    tbl[1] = '{0, 0, 1, 3};
    tbl[2] = '{1, 1, 0, 4};
    tbl[3] = '{2, 4, 0, 6};
    tbl[4] = '{5, 13, 1, 11};
    tbl[5] = '{3, 7, 0, 14};

    for (int i = 0; i < 3; i++) begin
      rst_i[i] = 1'b1;
      rv[i]    = 1'b0;
      rc[i]    = '0;
      prev_q[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_i[i] = 1'b0;

    // init window: not ready for INIT cycles, then ready
    for (int c = 0; c <= INIT; c++) begin
      @(negedge clk);
      chk($sformatf("init_ready_c%0d", c), rdy_o[0], c >= INIT);
      chk($sformatf("init_q_c%0d", c), q_o[0], 0);
      chk($sformatf("init_pulses_c%0d", c), ps_o[0], 0);
    end

    for (int k = 0; k < 6; k++) begin
      do_req(0, tbl[k].cnt);
      wait_idle(0, len);
      chk($sformatf("tbl%0d_len", k), len, tbl[k].exp_len);
      chk($sformatf("tbl%0d_q", k), q_o[0], tbl[k].exp_q);
      chk($sformatf("tbl%0d_total", k), ps_o[0], tbl[k].exp_tot);
      if (tbl[k].cnt == 0) chk("zero_cnt_ready", rdy_o[0], 1);
    end

    // MIN_GAP=1: four transitions on consecutive edges
    do_req(1, 4);
    @(negedge clk);
    chk("g1_latency_q", q_o[1], 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("g1_q%0d", k), q_o[1], (k % 2) == 0);
    end
    chk("g1_total", ps_o[1], 4);

    // MIN_GAP=4: back-to-back bursts, spacing checked across the boundary
    do_req(2, 2);
    do_req(2, 2);
    wait_idle(2, len);
    chk("b2b_q", q_o[2], 0);
    chk("b2b_total", ps_o[2], 4);

    // reset in the middle of a 5-pulse burst after 3 transitions
    base = int'(ps_o[0]);
    do_req(0, 5);
    for (int n = 0; n < 100 && int'(ps_o[0]) != base + 3; n++) @(negedge clk);
    chk("mid_q_before", q_o[0], 1);
    rst_i[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_i[0] = 1'b0;
    @(negedge clk);
    chk("rst_q", q_o[0], 0);
    chk("rst_total", ps_o[0], 0);
    chk("rst_ready", rdy_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    repeat (12) @(negedge clk);
    chk("rst_quiet_q", q_o[0], 0);
    chk("rst_quiet_total", ps_o[0], 0);
    do_req(0, 1);
    wait_idle(0, len);
    chk("post_rst_q", q_o[0], 1);

    // random traffic on all instances, requests held until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) acc[i] = rv[i] && rdy_o[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        rst_i[i] = ($urandom_range(0, 499) == 0);
        if (acc[i] || !rv[i]) begin
          rv[i] = ($urandom_range(0, 2) == 0);
          rc[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      rv[i]    = 1'b0;
      rst_i[i] = 1'b0;
    end
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sfq_toggle_tx.md
Name: sfq_toggle_tx

Overview:
- Synchronous transmitter that drives a toggle-encoded SFQ pulse line. Each pulse is one transition of `q`, either rising or falling, which is the encoding the downstream JTL/toggle cell models consume.
- Converts clocked burst requests ("emit N pulses") into correctly spaced transitions.
- Holds off after reset for an initialisation window, the equivalent of the cell models' `begin_time`.
- Enforces a minimum inter-pulse spacing so the receiving cell's critical-timing hold check is never violated.

Parameters:
- CNT_W, 8, width of the burst pulse-count request.
- MIN_GAP, 3, clock cycles between successive output transitions; legal range >= 1.
- INIT_CYCLES, 4, cycles after reset release before the first request is accepted; legal range >= 0.
- TOT_W, 16, width of the running pulse counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, burst request valid.
- req_count, input, CNT_W, number of pulses to emit in this burst.
- req_ready, output, 1, block can accept a request this cycle.
- q, output, 1, toggle-encoded pulse line; each transition is one pulse.
- busy, output, 1, a burst is in progress (EMIT or GAP state).
- pulses_sent, output, TOT_W, total transitions emitted since reset; wraps modulo 2^TOT_W.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values:
  - q = 0, req_ready = 0, busy = 0, pulses_sent = 0.
  - State = INIT, init counter = INIT_CYCLES, remaining = 0, gap counter = 0.
- Reset mid-burst: the burst is abandoned and q is forced to 0.
  - If q was 1, this is one extra transition. That transition is the decided behaviour and is not counted in pulses_sent.
- State INIT:
  - req_ready = 0.
  - Init counter decrements each cycle; move to IDLE on the cycle it reaches 0.
  - With INIT_CYCLES = 0, go straight to IDLE on the first cycle after reset.
- State IDLE:
  - req_ready = 1, busy = 0.
  - Handshake: the request is accepted when req_valid && req_ready at a clock edge. req_count is sampled at that edge.
  - req_count = 0: the request is consumed and the state stays IDLE; no transition, no counter change.
  - req_count > 0: remaining = req_count and the next state is EMIT.
- State EMIT (occupies one cycle):
  - At the end-of-cycle edge: q inverts, pulses_sent increments, remaining decrements.
  - If the new remaining = 0, go to IDLE.
  - Else if MIN_GAP = 1, stay in EMIT.
  - Else go to GAP with gap counter = MIN_GAP-1.
- State GAP:
  - Gap counter decrements each cycle; move to EMIT on the cycle it reaches 1.
- Timing:
  - Latency: request accepted at edge N gives the first transition at edge N+1.
  - Transition k (k counted from 0) occurs at edge N+1+k·MIN_GAP.
  - A burst of count C occupies the block for 1+(C-1)·MIN_GAP cycles after acceptance.
- Back-to-back bursts:
  - req_ready reasserts in the cycle after the last EMIT.
  - The first pulse of the next burst is therefore at least 2 cycles after the previous last pulse, which is >= MIN_GAP when MIN_GAP <= 2.
  - When MIN_GAP > 2, a holdoff counter keeps req_ready = 0 until MIN_GAP-1 cycles have elapsed since the last transition. Spacing is therefore never below MIN_GAP, including across bursts.
- Handshake rules:
  - req_valid while req_ready = 0 is ignored.
  - The requester must hold req_valid and req_count stable until accepted.
- q never changes except in an EMIT cycle or on reset.

Decomposition:
- Shared package `sfq_pkg`:
  - state enum (INIT, IDLE, EMIT, GAP);
  - default MIN_GAP;
  - default INIT_CYCLES, matching the cell library's begin_time expressed in cycles.
- One natural sub-module, `sfq_gap_timer`: a loadable down-counter with a `done` flag. It is reused for the INIT window, the GAP spacing and the inter-burst holdoff.

Test Plan:
- Reset then idle, INIT_CYCLES = 4:
  - req_ready = 0 for cycles 0–3 after reset release and = 1 from cycle 4.
  - q = 0 throughout.
  - pulses_sent = 0 throughout.
- Burst req_count = 3, MIN_GAP = 3, accepted at edge 10:
  - q toggles at edges 11, 14 and 17, ending with q = 1.
  - pulses_sent = 3.
  - busy is high for edges 11–17 and req_ready = 1 again at 18.
- MIN_GAP = 1, req_count = 4:
  - q toggles on 4 consecutive edges (0→1→0→1→0).
  - pulses_sent = 4.
- req_count = 0 accepted:
  - no transition, pulses_sent unchanged, req_ready stays 1.
- Back-to-back bursts of 2 then 2, MIN_GAP = 4:
  - every pair of adjacent transitions, including across the burst boundary, is separated by >= 4 cycles.
  - final q = 0, pulses_sent = 4.
- rst asserted mid-burst (count 5, after 3 transitions, q = 1):
  - next edge gives q = 0, pulses_sent = 0, state INIT.
  - no further transitions until a new request is made after INIT completes.
